// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Fixed 33-cycle latency: 32 one-bit steps, then sign fixup and writeback.
module muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic [DATA_WIDTH-1:0]     rs1_data,
  input  logic [DATA_WIDTH-1:0]     rs2_data,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
  input  logic                      flush,
  output logic                      busy,
  output logic                      wb_en,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data
);

  localparam int W = DATA_WIDTH;
  localparam logic [4:0] LAST = 5'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  state_e                    state_q, state_d;
  logic [4:0]                cnt_q, cnt_d;
  logic [2:0]                op_q, op_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [W-1:0]              a_q, a_d;
  logic [W-1:0]              b_q, b_d;
  logic [W-1:0]              araw_q, araw_d;
  logic [2*W-1:0]            prod_q, prod_d;
  logic [W:0]                rem_q, rem_d;
  logic                      neg_q, neg_d;
  logic                      divz_q, divz_d;
  logic                      wb_en_q, wb_en_d;
  logic [REG_ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic [W-1:0]              wb_data_q, wb_data_d;

  logic           a_sgn, b_sgn, sa, sb;
  logic [W-1:0]   a_abs, b_abs;
  logic [W:0]     mac, shl;
  logic [W+1:0]   diff;
  logic [2*W-1:0] pfix;
  logic [W-1:0]   qfix, rfix, res;

  always_comb begin
    a_sgn = (funct3 == 3'b001) || (funct3 == 3'b010)
         || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_sgn = (funct3 == 3'b001) || (funct3 == 3'b100)
         || (funct3 == 3'b110);
    sa    = a_sgn & rs1_data[W-1];
    sb    = b_sgn & rs2_data[W-1];
    a_abs = sa ? -rs1_data : rs1_data;
    b_abs = sb ? -rs2_data : rs2_data;
  end

  // Multiply: prod = {acc, multiplier}; divide: prod[W-1:0] = dividend/quotient.
  always_comb begin
    mac  = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, a_q} : '0);
    shl  = {rem_q[W-1:0], prod_q[W-1]};
    diff = {1'b0, shl} - {2'b00, b_q};
    pfix = neg_q ? -prod_q : prod_q;
    qfix = neg_q ? -prod_q[W-1:0] : prod_q[W-1:0];
    rfix = neg_q ? -rem_q[W-1:0] : rem_q[W-1:0];
  end

  always_comb begin
    res = '0;
    unique case (op_q)
      3'b000:                res = pfix[W-1:0];
      3'b001, 3'b010, 3'b011: res = pfix[2*W-1:W];
      3'b100, 3'b101:        res = divz_q ? '1 : qfix;
      3'b110, 3'b111:        res = divz_q ? araw_q : rfix;
      default:               res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    araw_d    = araw_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    divz_d    = divz_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = funct3;
          rd_d    = rd_addr;
          a_d     = a_abs;
          b_d     = b_abs;
          araw_d  = rs1_data;
          prod_d  = {{W{1'b0}}, funct3[2] ? a_abs : b_abs};
          rem_d   = '0;
          neg_d   = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
          divz_d  = funct3[2] && (rs2_data == '0);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (op_q[2]) begin
            rem_d  = diff[W+1] ? shl : diff[W:0];
            prod_d = {prod_q[2*W-1:W], prod_q[W-2:0], ~diff[W+1]};
          end else begin
            prod_d = {mac, prod_q[W-1:1]};
          end
          if (cnt_q == LAST) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!flush) begin
          wb_data_d = res;
          wb_addr_d = rd_q;
          wb_en_d   = (rd_q != '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      araw_q    <= '0;
      prod_q    <= '0;
      rem_q     <= '0;
      neg_q     <= 1'b0;
      divz_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      araw_q    <= araw_d;
      prod_q    <= prod_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      divz_q    <= divz_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign wb_en   = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Each task drives one scenario and checks results against hand values.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0]  rd_addr;
  logic        busy, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .flush(flush), .busy(busy), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  // Called at posedge+1; returns at accept edge +1 with inputs scrambled.
  task automatic issue(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
    funct3 = f; rs1_data = a; rs2_data = b; rd_addr = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom;
    rd_addr = 5'h1F; funct3 = 3'($urandom);
  endtask

  task automatic wait_wb(output int lat, output logic [31:0] d,
                         output logic [4:0] ad);
    lat = -1; d = '0; ad = '0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (wb_en) begin
        lat = i; d = wb_data; ad = wb_addr;
        break;
      end
    end
  endtask

  task automatic idle_cycles(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (wb_en) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_addr = '0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rst_wb_en got %b want 0", wb_en); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data got %h want 0", wb_data); end
    checks++; if (wb_addr !== 5'h0) begin errors++; $display("FAIL rst_wb_addr got %h want 0", wb_addr); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    int lat; logic [31:0] d; logic [4:0] ad;
    issue(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy got %b want 1", busy); end
    wait_wb(lat, d, ad);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_lat got %0d want 33", lat); end
    checks++; if (d !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_data got %h want FFFFFFEB", d); end
    checks++; if (ad !== 5'd5) begin errors++; $display("FAIL mul_addr got %0d want 5", ad); end
    @(posedge clk); #1;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL mul_strobe got %b want 0", wb_en); end
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6);
    wait_wb(lat, d, ad);
    checks++; if (d !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulhu_data got %h want FFFFFFFE", d); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL mulhu_lat got %0d want 33", lat); end
  endtask

  task automatic test_mulh;
    int lat; logic [31:0] d; logic [4:0] ad;
    issue(3'b001, 32'h80000000, 32'h80000000, 5'd7);
    wait_wb(lat, d, ad);
    checks++; if (d !== 32'h40000000) begin errors++; $display("FAIL mulh_data got %h want 40000000", d); end
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8);
    wait_wb(lat, d, ad);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu_data got %h want FFFFFFFF", d); end
    checks++; if (ad !== 5'd8) begin errors++; $display("FAIL mulhsu_addr got %0d want 8", ad); end
  endtask

  task automatic test_reset_midop;
    bit seen;
    issue(3'b000, 32'd9, 32'd9, 5'd4);
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", busy); end
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL mrst_wb_en got %b want 0", wb_en); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL mrst_wb_data got %h want 0", wb_data); end
    #1 reset = 1'b0;
    @(posedge clk); #1;
    idle_cycles(40, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mrst_no_wb got %b want 0", seen); end
  endtask

  task automatic test_div;
    logic [2:0]  f [8];
    logic [31:0] a [8];
    logic [31:0] b [8];
    logic [31:0] e [8];
    int lat; logic [31:0] d; logic [4:0] ad;
    f[0] = 3'b100; a[0] = 32'hFFFFFFF9; b[0] = 32'd2;        e[0] = 32'hFFFFFFFD;
    f[1] = 3'b110; a[1] = 32'hFFFFFFF9; b[1] = 32'd2;        e[1] = 32'hFFFFFFFF;
    f[2] = 3'b101; a[2] = 32'd100;      b[2] = 32'd7;        e[2] = 32'd14;
    f[3] = 3'b111; a[3] = 32'd100;      b[3] = 32'd7;        e[3] = 32'd2;
    f[4] = 3'b100; a[4] = 32'd5;        b[4] = 32'd0;        e[4] = 32'hFFFFFFFF;
    f[5] = 3'b110; a[5] = 32'd5;        b[5] = 32'd0;        e[5] = 32'd5;
    f[6] = 3'b100; a[6] = 32'h80000000; b[6] = 32'hFFFFFFFF; e[6] = 32'h80000000;
    f[7] = 3'b110; a[7] = 32'h80000000; b[7] = 32'hFFFFFFFF; e[7] = 32'h0;
    for (int i = 0; i < 8; i++) begin
      issue(f[i], a[i], b[i], 5'(i + 10));
      wait_wb(lat, d, ad);
      checks++; if (d !== e[i]) begin errors++; $display("FAIL div_data[%0d] got %h want %h", i, d, e[i]); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL div_lat[%0d] got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_divzero_extra;
    int lat; logic [31:0] d; logic [4:0] ad;
    issue(3'b101, 32'hFFFFFFF0, 32'd0, 5'd20);
    wait_wb(lat, d, ad);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0_data got %h want FFFFFFFF", d); end
    issue(3'b110, 32'hFFFFFFFB, 32'd0, 5'd21);
    wait_wb(lat, d, ad);
    checks++; if (d !== 32'hFFFFFFFB) begin errors++; $display("FAIL rem0neg_data got %h want FFFFFFFB", d); end
    issue(3'b100, 32'hFFFFFFFB, 32'd0, 5'd22);
    wait_wb(lat, d, ad);
    checks++; if (d !== 32'hFFFFFFFF) begin errors++; $display("FAIL div0neg_data got %h want FFFFFFFF", d); end
  endtask

  task automatic test_rd_zero;
    bit seen;
    issue(3'b000, 32'd3, 32'd4, 5'd0);
    idle_cycles(40, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rd0_wb got %b want 0", seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rd0_busy got %b want 0", busy); end
  endtask

  task automatic test_start_while_busy;
    int lat; logic [31:0] d; logic [4:0] ad;
    issue(3'b000, 32'd6, 32'd7, 5'd3);
    repeat (4) @(posedge clk);
    #1;
    funct3 = 3'b101; rs1_data = 32'd99; rs2_data = 32'd0; rd_addr = 5'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sbusy_busy got %b want 1", busy); end
    wait_wb(lat, d, ad);
    checks++; if (lat !== 28) begin errors++; $display("FAIL sbusy_lat got %0d want 28", lat); end
    checks++; if (d !== 32'd42) begin errors++; $display("FAIL sbusy_data got %h want 0000002a", d); end
    checks++; if (ad !== 5'd3) begin errors++; $display("FAIL sbusy_addr got %0d want 3", ad); end
  endtask

  task automatic test_flush;
    int lat; logic [31:0] d; logic [4:0] ad; bit seen;
    issue(3'b000, 32'h1234, 32'h10, 5'd7);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    idle_cycles(40, seen);
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_wb got %b want 0", seen); end
    flush = 1'b1;
    issue(3'b100, 32'd100, 32'hFFFFFFF9, 5'd9);
    flush = 1'b0;
    wait_wb(lat, d, ad);
    checks++; if (d !== 32'hFFFFFFF2) begin errors++; $display("FAIL flush_new_data got %h want FFFFFFF2", d); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL flush_new_lat got %0d want 33", lat); end
  endtask

  task automatic test_back_to_back;
    int lat; logic [31:0] d; logic [4:0] ad;
    issue(3'b101, 32'd100, 32'd7, 5'd10);
    wait_wb(lat, d, ad);
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL b2b_first got %h want 0000000e", d); end
    issue(3'b111, 32'd100, 32'd7, 5'd11);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b want 1", busy); end
    wait_wb(lat, d, ad);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_lat got %0d want 33", lat); end
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL b2b_data got %h want 00000002", d); end
    checks++; if (ad !== 5'd11) begin errors++; $display("FAIL b2b_addr got %0d want 11", ad); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_reset_midop();
    test_div();
    test_divzero_extra();
    test_rd_zero();
    test_start_while_busy();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit. It consumes operands read from the register file's rs1/rs2 ports and returns a result on a writeback port, which drives the register file's writeEnable/addr_write/write_data. It uses a fixed 33-cycle latency regardless of operation: 32 one-bit iterations, then a sign-fixup/writeback cycle.

Parameters:
DATA_WIDTH, 32, operand/result width; the algorithm and all test values are fixed at 32.
REG_ADDR_WIDTH, 5, destination register address width.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request; accepted only when busy=0.
funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1_data  in  DATA_WIDTH  operand a (dividend / multiplicand).
rs2_data  in  DATA_WIDTH  operand b (divisor / multiplier).
rd_addr  in  REG_ADDR_WIDTH  destination register.
flush  in  1  synchronous abort of the in-flight op.
busy  out  1  high while state != IDLE; combinational from the state register.
wb_en  out  1  registered one-cycle writeback strobe to the register file writeEnable.
wb_addr  out  REG_ADDR_WIDTH  registered destination address.
wb_data  out  DATA_WIDTH  registered result.

Behaviour:
- Reset (async): state=IDLE, busy=0, wb_en=0, wb_addr=0, wb_data=0, and all internal registers cleared. Reset mid-operation discards the op with no writeback.
- States: IDLE, CALC, FIN.
- IDLE, start=1 at edge E0:
  - latch funct3 and rd_addr;
  - latch |a| and |b| per signedness: MULH both signed; MULHSU a signed, b unsigned; DIV/REM both signed; all others unsigned;
  - latch the result sign flags;
  - count=0; go to CALC.
- CALC: one iteration per edge E1..E32; count increments; at count=31 go to FIN.
  - Multiply: shift-add into a 64-bit unsigned product register.
  - Divide: restoring, 33-bit partial remainder, one quotient bit per cycle.
- FIN, edge E33:
  - apply two's-complement sign fixup and select the result;
  - load wb_data and wb_addr; wb_en=1; go to IDLE.
  - wb_en returns to 0 at E34.
  - Latency from accept edge to wb_en edge is exactly 33 cycles.
- Result select:
  - MUL: low 32 of the signed/unsigned product (identical bits).
  - MULH / MULHSU / MULHU: high 32 of the 64-bit signed-corrected product.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Signed division signs: quotient negative iff sign(a) xor sign(b); remainder takes the sign of a.
- Division by zero (b=0):
  - quotient = 0xFFFFFFFF (both DIV and DIVU);
  - remainder = a, unmodified.
- Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- Special cases are resolved in FIN only; latency stays 33 cycles.
- rd_addr=0: op runs to completion, but wb_en is held 0 in FIN.
- start while busy=1: ignored; latched operands are unaffected.
- flush=1 in CALC or FIN: next edge goes to IDLE with no wb_en.
- flush in IDLE: ignored.
- flush and start together in IDLE: start is accepted.
- Back-to-back: the earliest next accept is edge E34, the first edge with busy=0.
- Inputs are sampled only at the accept edge; later changes to rs1_data/rs2_data/rd_addr have no effect.

Test Plan:
1. Reset: assert reset mid-CALC -> busy=0, wb_en=0, wb_data=0 immediately; no writeback ever follows.
2. MUL a=7, b=0xFFFFFFFD, rd=5 -> exactly 33 cycles later wb_en=1 for one cycle, wb_addr=5, wb_data=0xFFFFFFEB. Then MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
3. High-product ops:
   - MULH 0x80000000 x 0x80000000 -> 0x40000000.
   - MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
4. Division:
   - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU -> 2.
5. Corner cases:
   - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0.
   - All of these complete in 33 cycles.
6. Control:
   - rd=0 op -> wb_en never asserts.
   - start pulsed during busy -> ignored; the original result is correct.
   - flush at CALC cycle 10 -> busy=0 next cycle, no wb_en.
   - A new start at that point gives the correct result.
